// File: rtl/axi_traffic_gen.sv
// AXI traffic generator: writes one incrementing-pattern burst, reads it back
// and counts read beats whose data, ID or RLAST do not match the pattern.
package axi_traffic_gen_pkg;
   localparam int AXI_DATA_W = 32;
   localparam int AXI_ADDR_W = 16;
   localparam int AXI_ID_W_W = 4;
   localparam int AXI_ID_R_W = 4;

   typedef struct packed {
      logic                    awvalid;
      logic [AXI_ADDR_W-1:0]   awaddr;
      logic [7:0]              awlen;
      logic [2:0]              awsize;
      logic [1:0]              awburst;
      logic [AXI_ID_W_W-1:0]   awid;
      logic                    wvalid;
      logic [AXI_DATA_W-1:0]   wdata;
      logic [AXI_DATA_W/8-1:0] wstrb;
      logic                    wlast;
      logic                    bready;
      logic                    arvalid;
      logic [AXI_ADDR_W-1:0]   araddr;
      logic [7:0]              arlen;
      logic [2:0]              arsize;
      logic [1:0]              arburst;
      logic [AXI_ID_R_W-1:0]   arid;
      logic                    rready;
   } axi_mosi_t;

   typedef struct packed {
      logic                    awready;
      logic                    wready;
      logic                    bvalid;
      logic [AXI_ID_W_W-1:0]   bid;
      logic                    arready;
      logic                    rvalid;
      logic [AXI_DATA_W-1:0]   rdata;
      logic [AXI_ID_R_W-1:0]   rid;
      logic                    rlast;
   } axi_miso_t;
endpackage

module axi_traffic_gen
   import axi_traffic_gen_pkg::*;
#(
   parameter int AXI_DATA_WIDTH = AXI_DATA_W,
   parameter int ADDR_WIDTH     = AXI_ADDR_W,
   parameter int ID_W_WIDTH     = AXI_ID_W_W,
   parameter int ID_R_WIDTH     = AXI_ID_R_W
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      start_i,
   input  logic [ADDR_WIDTH-1:0]     addr_i,
   input  logic [7:0]                len_i,
   input  logic [ID_W_WIDTH-1:0]     id_i,
   input  logic [AXI_DATA_WIDTH-1:0] seed_i,
   output axi_mosi_t                 m_axi_o,
   input  axi_miso_t                 m_axi_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      error_o,
   output logic [7:0]                err_cnt_o
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] AW   = 3'd1;
   localparam logic [2:0] W    = 3'd2;
   localparam logic [2:0] B    = 3'd3;
   localparam logic [2:0] AR   = 3'd4;
   localparam logic [2:0] R    = 3'd5;
   localparam logic [2:0] DONE = 3'd6;

   localparam logic [2:0] AXI_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));

   logic [2:0]                state_q,   state_d;
   logic [ADDR_WIDTH-1:0]     addr_q,    addr_d;
   logic [7:0]                len_q,     len_d;
   logic [ID_W_WIDTH-1:0]     id_q,      id_d;
   logic [AXI_DATA_WIDTH-1:0] seed_q,    seed_d;
   logic [7:0]                beat_q,    beat_d;
   logic [7:0]                err_cnt_q, err_cnt_d;
   logic                      bid_err_q, bid_err_d;

   logic                      last_beat;
   logic [AXI_DATA_WIDTH-1:0] pattern;
   logic                      rd_bad;

   assign last_beat = (beat_q == len_q);
   assign pattern   = seed_q + AXI_DATA_WIDTH'(beat_q);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      id_d      = id_q;
      seed_d    = seed_q;
      beat_d    = beat_q;
      err_cnt_d = err_cnt_q;
      bid_err_d = bid_err_q;
      rd_bad    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               addr_d    = addr_i;
               len_d     = len_i;
               id_d      = id_i;
               seed_d    = seed_i;
               beat_d    = 8'd0;
               err_cnt_d = 8'd0;
               bid_err_d = 1'b0;
               state_d   = AW;
            end
         end
         AW: if (m_axi_i.awready) state_d = W;
         W: begin
            if (m_axi_i.wready) begin
               if (last_beat) begin
                  beat_d  = 8'd0;
                  state_d = B;
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end
         end
         B: begin
            if (m_axi_i.bvalid) begin
               if (m_axi_i.bid != id_q) bid_err_d = 1'b1;
               state_d = AR;
            end
         end
         AR: begin
            if (m_axi_i.arready) begin
               beat_d  = 8'd0;
               state_d = R;
            end
         end
         R: begin
            // The beat counter sticks at len so over-long bursts keep failing the RLAST check.
            if (m_axi_i.rvalid) begin
               rd_bad = (m_axi_i.rdata != pattern)
                     || (m_axi_i.rid != id_q[ID_R_WIDTH-1:0])
                     || (m_axi_i.rlast != last_beat);
               if (rd_bad && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
               if (m_axi_i.rlast)   state_d = DONE;
               else if (!last_beat) beat_d  = beat_q + 8'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         id_q      <= '0;
         seed_q    <= '0;
         beat_q    <= '0;
         err_cnt_q <= '0;
         bid_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         id_q      <= id_d;
         seed_q    <= seed_d;
         beat_q    <= beat_d;
         err_cnt_q <= err_cnt_d;
         bid_err_q <= bid_err_d;
      end
   end

   // Payloads are always driven from the latched test; only the handshake bits depend on state.
   always_comb begin
      m_axi_o         = '0;
      m_axi_o.awvalid = (state_q == AW);
      m_axi_o.awaddr  = addr_q;
      m_axi_o.awlen   = len_q;
      m_axi_o.awsize  = AXI_SIZE;
      m_axi_o.awburst = 2'b01;
      m_axi_o.awid    = id_q;
      m_axi_o.wvalid  = (state_q == W);
      m_axi_o.wdata   = pattern;
      m_axi_o.wstrb   = '1;
      m_axi_o.wlast   = last_beat;
      m_axi_o.bready  = (state_q == B);
      m_axi_o.arvalid = (state_q == AR);
      m_axi_o.araddr  = addr_q;
      m_axi_o.arlen   = len_q;
      m_axi_o.arsize  = AXI_SIZE;
      m_axi_o.arburst = 2'b01;
      m_axi_o.arid    = id_q[ID_R_WIDTH-1:0];
      m_axi_o.rready  = (state_q == R);
   end

   assign busy_o    = (state_q != IDLE);
   assign done_o    = (state_q == DONE);
   assign error_o   = bid_err_q || (err_cnt_q != 8'd0);
   assign err_cnt_o = err_cnt_q;

endmodule
